button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Consumes the active-low debounced push-button level produced by the board's debounce stage.
- Converts that level into single-cycle event pulses: press, release, long-press and auto-repeat.
- Also provides held-status levels and a wrapping press counter.
- Sits between the debouncer and the lab's control FSMs/counters, so those FSMs never edge-detect or time buttons themselves.

Parameters:
- ACTIVE_LOW, 1: 1 = pb_debounced low means pressed; 0 = high means pressed.
- CNT_W, 24: width of the internal hold timer.
- LONG_CYC, 1000000: number of consecutive pressed samples before long_pulse fires. Legal range 2 .. 2^CNT_W-1.
- REPEAT_CYC, 250000: cycles between repeat_pulse while long-held. 0 disables repeat. Legal range 0 .. 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- pb_debounced  input  1  debounced button level, already in clk domain.
- press_pulse  output  1  one-cycle pulse on press.
- release_pulse  output  1  one-cycle pulse on release.
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_CYC.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYC while long-held.
- held  output  1  level; 1 while state is PRESS or HOLD.
- long_held  output  1  level; 1 while state is HOLD.
- press_count  output  8  number of press events, wrapping.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Pressed flag: p = ACTIVE_LOW ? ~pb_debounced : pb_debounced. p is combinational; there is no extra input register.
- Reset (rst=1 at an edge) sets:
  - state=IDLE, timer=0, press_count=0;
  - all pulse outputs=0, held=0, long_held=0.
- All outputs are registered. Every event pulse is high for exactly the one cycle after the edge that sampled the causing condition (latency 1).
- FSM, evaluated at each rising edge with rst=0:
  - IDLE:
    - p=1 -> PRESS; press_pulse=1; timer=1; press_count+1.
    - Otherwise stay in IDLE; timer=0.
  - PRESS:
    - p=0 -> IDLE; release_pulse=1.
    - Else, if timer==LONG_CYC-1 -> HOLD; long_pulse=1; timer=0.
    - Else timer+1.
  - HOLD:
    - p=0 -> IDLE; release_pulse=1.
    - Else, if REPEAT_CYC!=0 and timer==REPEAT_CYC-1 -> repeat_pulse=1; timer=0.
    - Else, if REPEAT_CYC!=0, timer+1.
    - If REPEAT_CYC==0, the timer holds at 0.
- Resulting timing, taking the press edge as edge 0:
  - long_pulse follows edge LONG_CYC-1, i.e. LONG_CYC-1 cycles after press_pulse.
  - The k-th repeat_pulse follows edge LONG_CYC-1+k*REPEAT_CYC.
- Simultaneous events:
  - Release has priority over the long/repeat threshold in the same cycle.
  - A release sampled at the threshold edge gives release_pulse only, with no long_pulse or repeat_pulse.
  - At most one pulse output is high in any cycle.
- press_count: increments only on the IDLE->PRESS transition; 8'hFF wraps to 8'h00 with no flag.
- held and long_held:
  - They update on the same edge as the transition, so held rises together with press_pulse and falls together with release_pulse.
  - long_held rises together with long_pulse.
- Reset mid-press or mid-hold:
  - The FSM returns to IDLE with no release_pulse.
  - If p=1 at the first edge after rst deasserts, this is a new press: press_pulse fires and timing restarts from that edge.
- A one-sample release glitch is not filtered: PRESS/HOLD -> IDLE -> PRESS produces release_pulse then press_pulse on consecutive cycles. Filtering is the debouncer's job.
- The timer never exceeds max(LONG_CYC, REPEAT_CYC)-1 and never wraps.

Test Plan:
All scenarios use ACTIVE_LOW=1, LONG_CYC=8, REPEAT_CYC=4, CNT_W=4.
1. Short press: after reset, drive pb_debounced=0 for 3 cycles then 1.
   -> press_pulse for 1 cycle after edge 0; held=1 for 3 cycles; release_pulse 1 cycle after edge 3; no long_pulse; press_count=1.
2. Long press with repeat: hold pb_debounced=0 for 20 cycles.
   -> press_pulse after edge 0; long_pulse after edge 7; long_held=1 from then on; repeat_pulse after edges 11, 15 and 19; release_pulse on release; no overlapping pulses.
3. Threshold race: release at exactly edge 7 (pb_debounced=1 sampled at edge 7).
   -> release_pulse only; long_pulse never asserted; long_held stays 0.
4. Counter wrap: perform 256 short presses.
   -> press_count returns to 8'h00; press 257 gives 8'h01.
5. Reset mid-hold: pulse rst for 1 cycle during HOLD while the button stays pressed.
   -> all outputs 0 during reset with no release_pulse; press_pulse at the first edge after reset; long_pulse 7 cycles later.
6. Parameter variant: ACTIVE_LOW=0, REPEAT_CYC=0, drive pb_debounced=1 for 20 cycles.
   -> press_pulse and long_pulse occur; zero repeat_pulse; release_pulse when the input returns to 0.

Source files
------------

// File: rtl/button_event_decoder.sv
// Turns a debounced push-button level into registered press/release/long/repeat pulses,
// held-status levels and a wrapping press counter.
module button_event_decoder #(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned LONG_CYC   = 1000000,
  parameter int unsigned REPEAT_CYC = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_debounced,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic       long_held,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {StIdle, StPress, StHold} state_e;

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYC - 1);
  // Only meaningful when REPEAT_CYC != 0; every use is guarded by that condition.
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             p;

  assign p = ACTIVE_LOW ? ~pb_debounced : pb_debounced;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (p) begin
          state_d = StPress;
          press_d = 1'b1;
          timer_d = CNT_W'(1);
          cnt_d   = cnt_q + 8'd1;
        end else begin
          timer_d = '0;
        end
      end
      StPress: begin
        // Release wins over the long-press threshold in the same cycle.
        if (!p) begin
          state_d = StIdle;
          rel_d   = 1'b1;
        end else if (timer_q == LongLast) begin
          state_d = StHold;
          long_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (!p) begin
          state_d = StIdle;
          rel_d   = 1'b1;
        end else if (REPEAT_CYC != 0) begin
          if (timer_q == RepeatLast) begin
            rep_d   = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rep_q;
  assign held          = (state_q != StIdle);
  assign long_held     = (state_q == StHold);
  assign press_count   = cnt_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: stimulus queues expected events, a monitor
// process pops and compares them whenever a pulse output fires.
module tb_button_event_decoder;

  localparam logic [3:0] EvPress = 4'b1000;
  localparam logic [3:0] EvRel   = 4'b0100;
  localparam logic [3:0] EvLong  = 4'b0010;
  localparam logic [3:0] EvRep   = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] pulses;
    logic [7:0] cnt;
    logic       held;
    logic       lh;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       pb;
  logic       pb0;
  logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held, long_held;
  logic [7:0] press_count;
  logic       press_pulse0, release_pulse0, long_pulse0, repeat_pulse0, held0, long_held0;
  logic [7:0] press_count0;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cnt = 8'd0;
  logic [7:0] cnt0 = 8'd0;
  ev_t        q[$];
  ev_t        q0[$];

  button_event_decoder #(
    .ACTIVE_LOW(1'b1), .CNT_W(4), .LONG_CYC(8), .REPEAT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .pb_debounced(pb),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .held(held), .long_held(long_held),
    .press_count(press_count)
  );

  button_event_decoder #(
    .ACTIVE_LOW(1'b0), .CNT_W(4), .LONG_CYC(8), .REPEAT_CYC(0)
  ) dut0 (
    .clk(clk), .rst(rst), .pb_debounced(pb0),
    .press_pulse(press_pulse0), .release_pulse(release_pulse0), .long_pulse(long_pulse0),
    .repeat_pulse(repeat_pulse0), .held(held0), .long_held(long_held0),
    .press_count(press_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit v, input int c, input logic [3:0] p, input logic [7:0] n,
                      input logic h, input logic l);
    ev_t e;
    e.cyc = c; e.pulses = p; e.cnt = n; e.held = h; e.lh = l;
    if (v) q0.push_back(e);
    else q.push_back(e);
  endtask

  // Compares one DUT's pulse activity in this cycle against the head of its queue.
  task automatic check_ev(input bit v, input logic [3:0] p, input logic [7:0] n,
                          input logic h, input logic l);
    ev_t e;
    if ((|p) === 1'b1) begin
      checks++;
      if ((v ? q0.size() : q.size()) == 0) begin
        errors++;
        $display("FAIL unexpected_event dut%0d: cyc %0d pulses %b, required none", v, cyc, p);
      end else begin
        e = v ? q0.pop_front() : q.pop_front();
        if (e.cyc != cyc || e.pulses !== p || e.cnt !== n || e.held !== h || e.lh !== l) begin
          errors++;
          $display("FAIL event dut%0d: got cyc %0d pulses %b cnt %0d held %b lh %b, required cyc %0d pulses %b cnt %0d held %b lh %b",
                   v, cyc, p, n, h, l, e.cyc, e.pulses, e.cnt, e.held, e.lh);
        end
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      check_ev(1'b0, {press_pulse, release_pulse, long_pulse, repeat_pulse}, press_count,
               held, long_held);
      check_ev(1'b1, {press_pulse0, release_pulse0, long_pulse0, repeat_pulse0}, press_count0,
               held0, long_held0);
    end
  endtask

  // Press for hold_n sampled edges, release for one edge plus gap idle edges.
  task automatic do_press(input bit v, input int hold_n, input int rep, input int gap);
    int         e0;
    logic [7:0] n;
    e0 = cyc + 1;
    if (v) begin pb0 = 1'b1; cnt0 = cnt0 + 8'd1; n = cnt0; end
    else begin pb = 1'b0; cnt = cnt + 8'd1; n = cnt; end
    push(v, e0, EvPress, n, 1'b1, 1'b0);
    if (hold_n >= 8) begin
      push(v, e0 + 7, EvLong, n, 1'b1, 1'b1);
      if (rep != 0)
        for (int k = 1; 7 + k * rep <= hold_n - 1; k++)
          push(v, e0 + 7 + k * rep, EvRep, n, 1'b1, 1'b1);
    end
    push(v, e0 + hold_n, EvRel, n, 1'b0, 1'b0);
    repeat (hold_n) tick();
    if (v) pb0 = 1'b0;
    else pb = 1'b1;
    repeat (1 + gap) tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    chk("rst_held", held, 0);
    chk("rst_long_held", long_held, 0);
    chk("rst_count", press_count, 0);
    chk("rst_pulses", {press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
    chk("rst_count0", press_count0, 0);
    rst = 1'b0;
    cnt = 8'd0;
    cnt0 = 8'd0;
  endtask

  initial begin
    int e0;
    rst = 1'b1;
    pb = 1'b1;
    pb0 = 1'b0;
    fork
      monitor();
    join_none
    tick();
    reset_dut();
    tick();

    // Short press, long press with repeats, release at the long threshold.
    do_press(1'b0, 3, 4, 2);
    do_press(1'b0, 20, 4, 2);
    do_press(1'b0, 7, 4, 2);

    // Reset while in HOLD with the button still pressed.
    e0 = cyc + 1;
    pb = 1'b0;
    cnt = cnt + 8'd1;
    push(1'b0, e0, EvPress, cnt, 1'b1, 1'b0);
    push(1'b0, e0 + 7, EvLong, cnt, 1'b1, 1'b1);
    repeat (9) tick();
    chk("hold_before_rst", long_held, 1);
    reset_dut();
    do_press(1'b0, 10, 4, 2);

    // Counter wrap after 256 presses, then one more.
    reset_dut();
    repeat (256) do_press(1'b0, 1, 4, 1);
    chk("wrap_count", press_count, 0);
    do_press(1'b0, 1, 4, 1);
    chk("wrap_plus_one", press_count, 1);

    // Active-high variant with repeat disabled.
    do_press(1'b1, 20, 0, 2);
    chk("variant_count", press_count0, 1);

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    chk("queue0_drained", q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
